// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a DIM x DIM systolic MAC array. One job per accepted start:
// load C accumulators, stream skewed A/B operands, read back C rows, pulse done.
module systolic_seq_ctrl #(
    parameter int DIM = 8,
    parameter int KW  = $clog2(DIM),
    parameter int TW  = $clog2(3*DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear_c,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              sa_en,
    output logic              sa_WrEn,
    output logic [KW-1:0]     sa_Crow,
    output logic              c_zero,
    output logic              c_rd_valid,
    output logic [DIM-1:0]    a_rd_en,
    output logic [DIM*KW-1:0] a_rd_idx,
    output logic [DIM-1:0]    b_rd_en,
    output logic [DIM*KW-1:0] b_rd_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_C,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    // Last step index of each counted phase; the last step always moves on.
    localparam logic [TW-1:0] LOAD_LAST    = TW'(DIM - 1);
    localparam logic [TW-1:0] COMPUTE_LAST = TW'(3*DIM - 3);
    localparam logic [TW-1:0] DRAIN_LAST   = TW'(DIM - 1);

    state_t        state_reg, state_next;
    logic [TW-1:0] t_reg, t_next;
    logic          clear_c_reg, clear_c_next;
    logic          compute_active;

    // State, step counter and latched clear_c; rst aborts any job silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            t_reg       <= '0;
            clear_c_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            t_reg       <= t_next;
            clear_c_reg <= clear_c_next;
        end
    end

    // Next-state logic and Moore outputs; hold only gates the strobes.
    always_comb begin
        state_next   = state_reg;
        t_next       = t_reg;
        clear_c_next = clear_c_reg;
        busy         = 1'b0;
        done         = 1'b0;
        sa_en        = 1'b0;
        sa_WrEn      = 1'b0;
        sa_Crow      = '0;
        c_zero       = 1'b0;
        c_rd_valid   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_LOAD_C;
                    t_next       = '0;
                    clear_c_next = clear_c;
                end
            end
            S_LOAD_C: begin
                busy    = 1'b1;
                sa_WrEn = ~hold;
                sa_Crow = t_reg[KW-1:0];
                c_zero  = clear_c_reg;
                if (!hold) begin
                    if (t_reg == LOAD_LAST) begin
                        state_next = S_COMPUTE;
                        t_next     = '0;
                    end else begin
                        t_next = t_reg + TW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                busy  = 1'b1;
                sa_en = ~hold;
                if (!hold) begin
                    if (t_reg == COMPUTE_LAST) begin
                        state_next = S_DRAIN;
                        t_next     = '0;
                    end else begin
                        t_next = t_reg + TW'(1);
                    end
                end
            end
            S_DRAIN: begin
                busy       = 1'b1;
                c_rd_valid = ~hold;
                sa_Crow    = t_reg[KW-1:0];
                if (!hold) begin
                    if (t_reg == DRAIN_LAST) begin
                        state_next = S_DONE;
                        t_next     = '0;
                    end else begin
                        t_next = t_reg + TW'(1);
                    end
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
                t_next     = '0;
            end
            default: begin
                state_next = S_IDLE;
                t_next     = '0;
            end
        endcase
    end

    assign compute_active = (state_reg == S_COMPUTE);

    // Operand skew: lane gi is active for DIM steps starting at step gi.
    // t - gi wraps to a value >= DIM when t < gi because 2**TW >= 3*DIM,
    // so a single unsigned compare covers both window edges.
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
            localparam logic [TW-1:0] LANE_OFS = TW'(gi);
            logic [TW-1:0] lane_diff;
            logic          lane_win;
            assign lane_diff = t_reg - LANE_OFS;
            assign lane_win  = compute_active && (lane_diff < TW'(DIM));
            assign a_rd_en[gi] = lane_win & ~hold;
            assign b_rd_en[gi] = lane_win & ~hold;
            assign a_rd_idx[gi*KW +: KW] = lane_win ? lane_diff[KW-1:0] : '0;
            assign b_rd_idx[gi*KW +: KW] = lane_win ? lane_diff[KW-1:0] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl (DIM=4). Every driven cycle pushes
// the expected output word, derived from the job position timeline, onto a
// queue; a negedge monitor pops and compares it with the DUT outputs.
module tb_systolic_seq_ctrl;

    localparam int DIM  = 4;
    localparam int KW   = 2;
    localparam int LAST = 5*DIM - 1;   // job position of the done cycle

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              clear_c = 1'b0;
    logic              hold = 1'b0;
    logic              busy, done, sa_en, sa_WrEn, c_zero, c_rd_valid;
    logic [KW-1:0]     sa_Crow;
    logic [DIM-1:0]    a_rd_en, b_rd_en;
    logic [DIM*KW-1:0] a_rd_idx, b_rd_idx;

    systolic_seq_ctrl #(.DIM(DIM)) dut (
        .clk(clk), .rst(rst), .start(start), .clear_c(clear_c), .hold(hold),
        .busy(busy), .done(done), .sa_en(sa_en), .sa_WrEn(sa_WrEn),
        .sa_Crow(sa_Crow), .c_zero(c_zero), .c_rd_valid(c_rd_valid),
        .a_rd_en(a_rd_en), .a_rd_idx(a_rd_idx),
        .b_rd_en(b_rd_en), .b_rd_idx(b_rd_idx)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = -1;
    int          m_pos = 0;
    bit          m_cz = 1'b0;
    bit          model_valid = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Expected output word from the job position: 0 idle, 1..DIM load,
    // then 3*DIM-2 compute steps, DIM drain steps, then done.
    // Layout: busy,done,en,wren,crow[2],czero,crv,aen[4],aidx[8],ben[4],bidx[8]
    function automatic logic [31:0] exp_out(input int pos, input bit hd, input bit cz);
        logic          e_busy, e_done, e_en, e_wren, e_cz, e_crv;
        logic [KW-1:0] e_crow;
        logic [3:0]    e_aen;
        logic [7:0]    e_aidx;
        int            t;
        e_busy = 1'b0; e_done = 1'b0; e_en = 1'b0; e_wren = 1'b0;
        e_cz = 1'b0; e_crv = 1'b0; e_crow = '0; e_aen = '0; e_aidx = '0;
        if (pos != 0) begin
            e_busy = 1'b1;
            if (pos <= DIM) begin
                t = pos - 1;
                e_wren = !hd;
                e_crow = KW'(t);
                e_cz   = cz;
            end else if (pos <= 4*DIM - 2) begin
                t = pos - DIM - 1;
                e_en = !hd;
                for (int i = 0; i < DIM; i++) begin
                    if (t >= i && t <= i + DIM - 1) begin
                        e_aen[i] = !hd;
                        e_aidx[i*KW +: KW] = KW'(t - i);
                    end
                end
            end else if (pos <= 5*DIM - 2) begin
                t = pos - (4*DIM - 1);
                e_crv  = !hd;
                e_crow = KW'(t);
            end else begin
                e_done = 1'b1;
            end
        end
        return {e_busy, e_done, e_en, e_wren, e_crow, e_cz, e_crv,
                e_aen, e_aidx, e_aen, e_aidx};
    endfunction

    // One clock of stimulus: drive, record expectation, advance the model.
    task automatic step(input bit st, input bit cc, input bit hd, input bit rs);
        start = st; clear_c = cc; hold = hd; rst = rs;
        if (model_valid) exp_q.push_back(exp_out(m_pos, hd, m_cz));
        @(posedge clk);
        if (rs) begin
            m_pos = 0; m_cz = 1'b0;
        end else if (m_pos == 0) begin
            if (st) begin m_pos = 1; m_cz = cc; end
        end else if (m_pos == LAST) begin
            m_pos = 0;
        end else if (!hd) begin
            m_pos++;
        end
        model_valid = 1'b1;
        cyc++;
        #1;
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle.
    always @(negedge clk) begin
        logic [31:0] obs, e;
        obs = {busy, done, sa_en, sa_WrEn, sa_Crow, c_zero, c_rd_valid,
               a_rd_en, a_rd_idx, b_rd_en, b_rd_idx};
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("ctl", 32'(obs[31:24]), 32'(e[31:24]));
            check_val("a",   32'(obs[23:12]), 32'(e[23:12]));
            check_val("b",   32'(obs[11:0]),  32'(e[11:0]));
        end
    end

    task automatic job_start_mark(output int s0);
        s0 = cyc; done_cnt = 0; last_done_cyc = -1;
    endtask

    task automatic job_report(input string name, input int s0, input int exp_lat, input int exp_dones);
        check_val({name, "_dones"}, 32'(done_cnt), 32'(exp_dones));
        if (exp_dones > 0)
            check_val({name, "_lat"}, 32'(last_done_cyc - s0), 32'(exp_lat));
        $display("job %s: start cyc %0d, dones %0d, last done cyc %0d", name, s0, done_cnt, last_done_cyc);
    endtask

    initial begin
        int s0;
        @(posedge clk); #1;

        // Reset held with start asserted, then idle with hold toggling.
        repeat (3) step(1, 1, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        $display("reset: idle checked at cyc %0d", cyc);

        // Normal job.
        job_start_mark(s0);
        for (int k = 0; k <= 21; k++) step(k == 0, 0, 0, 0);
        job_report("normal", s0, 19, 1);

        // Hold for 3 cycles at compute step 5.
        job_start_mark(s0);
        for (int k = 0; k <= 24; k++) step(k == 0, 0, (k >= 10 && k <= 12), 0);
        job_report("hold_compute", s0, 22, 1);

        // Extra start pulses mid-job and in DONE are ignored.
        job_start_mark(s0);
        for (int k = 0; k <= 25; k++) step(k == 0 || k == 8 || k == 19, 0, 0, 0);
        job_report("extra_start", s0, 19, 1);

        // Reset mid-compute aborts without done.
        job_start_mark(s0);
        for (int k = 0; k <= 13; k++) step(k == 0, 0, 0, k == 10);
        job_report("abort", s0, 0, 0);

        job_start_mark(s0);
        for (int k = 0; k <= 21; k++) step(k == 0, 0, 0, 0);
        job_report("after_abort", s0, 19, 1);

        // clear_c latched at start; hold in LOAD_C counts, hold in DONE does not.
        job_start_mark(s0);
        for (int k = 0; k <= 23; k++) step(k == 0, k == 0, (k == 2 || k == 20), 0);
        job_report("clear_c", s0, 20, 1);

        // Hold during DRAIN.
        job_start_mark(s0);
        for (int k = 0; k <= 24; k++) step(k == 0, 0, (k == 16 || k == 17), 0);
        job_report("hold_drain", s0, 21, 1);

        step(0, 0, 0, 0);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
